// File: rtl/ps2_key_tx.sv
// ============================================================================
// Module      : ps2_key_tx
// Description : Buffers key events and sends them to a PS/2 keyboard receiver
//               as device-side frames (E0 / F0 prefixes, odd parity).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_tx #(
  parameter int HALF_BIT   = 2500,
  parameter int GAP        = 5000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic        ps2_clk,
  output logic        ps2_dat,
  output logic        busy,
  output logic        overflow
);

  localparam int c_HW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
  localparam int c_GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int c_PW = $clog2(FIFO_DEPTH);

  localparam logic [c_HW-1:0] c_HALF_LAST = c_HW'(HALF_BIT - 1);
  localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'(GAP - 1);
  localparam logic [c_PW:0]   c_FULL      = (c_PW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]      c_LAST_BIT  = 4'd10;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_LOAD  = 2'd1;
  localparam logic [1:0] c_ST_SHIFT = 2'd2;
  localparam logic [1:0] c_ST_GAP   = 2'd3;

  // --------------------------------------------------------------------------
  // Event detection and FIFO
  // --------------------------------------------------------------------------
  logic              r_toggle;
  logic [9:0]        r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [c_PW:0]     r_count;
  logic [c_PW:0]     w_count_nxt;
  logic [9:0]        w_head;
  logic              w_event;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  assign w_event = ps2_key[10] != r_toggle;
  assign w_full  = r_count == c_FULL;
  assign w_empty = r_count == '0;
  assign w_pop   = (r_state == c_ST_IDLE) && !w_empty;
  // A full FIFO still accepts an event when the head leaves on the same cycle
  assign w_push  = w_event && (!w_full || w_pop);
  assign w_drop  = w_event && w_full && !w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + (c_PW + 1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - (c_PW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_toggle <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_event) begin
        r_toggle <= ps2_key[10];
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ps2_key[9:0];
    end
  end

  // --------------------------------------------------------------------------
  // Frame sequencer
  // --------------------------------------------------------------------------
  logic              r_need_e0;
  logic              r_need_f0;
  logic              r_last;
  logic [7:0]        r_code;
  logic [10:0]       r_frame;
  logic              r_clk;
  logic              r_phase;
  logic [c_HW-1:0]   r_half;
  logic [3:0]        r_bit;
  logic [c_GW-1:0]   r_gap;
  logic              r_busy;
  logic              r_overflow;
  logic [7:0]        w_byte;
  logic              w_half_end;
  logic              w_gap_end;

  assign w_half_end = r_half == c_HALF_LAST;
  assign w_gap_end  = r_gap == c_GAP_LAST;
  assign w_byte     = r_need_e0 ? 8'hE0 : (r_need_f0 ? 8'hF0 : r_code);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_pop) begin
          w_state_nxt = c_ST_LOAD;
        end
      end
      c_ST_LOAD: begin
        w_state_nxt = c_ST_SHIFT;
      end
      c_ST_SHIFT: begin
        if (w_half_end && r_phase && (r_bit == c_LAST_BIT)) begin
          w_state_nxt = c_ST_GAP;
        end
      end
      c_ST_GAP: begin
        if (w_gap_end) begin
          w_state_nxt = r_last ? c_ST_IDLE : c_ST_LOAD;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= c_ST_IDLE;
      r_need_e0 <= 1'b0;
      r_need_f0 <= 1'b0;
      r_last    <= 1'b0;
      r_code    <= '0;
      r_frame   <= '1;
      r_clk     <= 1'b1;
      r_phase   <= 1'b0;
      r_half    <= '0;
      r_bit     <= '0;
      r_gap     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        c_ST_IDLE: begin
          if (w_pop) begin
            r_need_e0 <= w_head[8];
            r_need_f0 <= ~w_head[9];
            r_code    <= w_head[7:0];
            r_last    <= 1'b0;
          end
        end
        c_ST_LOAD: begin
          // Frame is shifted out LSB first: start, data[0..7], parity, stop
          r_frame <= {1'b1, ~^w_byte, w_byte, 1'b0};
          if (r_need_e0) begin
            r_need_e0 <= 1'b0;
          end else if (r_need_f0) begin
            r_need_f0 <= 1'b0;
          end else begin
            r_last <= 1'b1;
          end
          r_clk   <= 1'b1;
          r_phase <= 1'b0;
          r_half  <= '0;
          r_bit   <= '0;
          r_gap   <= '0;
        end
        c_ST_SHIFT: begin
          if (w_half_end) begin
            r_half <= '0;
            if (!r_phase) begin
              r_clk   <= 1'b0;
              r_phase <= 1'b1;
            end else begin
              r_clk   <= 1'b1;
              r_phase <= 1'b0;
              // Ones shift in behind the stop bit so the line rests high
              r_frame <= {1'b1, r_frame[10:1]};
              if (r_bit == c_LAST_BIT) begin
                r_bit <= '0;
                r_gap <= '0;
              end else begin
                r_bit <= r_bit + 4'd1;
              end
            end
          end else begin
            r_half <= r_half + c_HW'(1);
          end
        end
        c_ST_GAP: begin
          if (w_gap_end) begin
            r_gap <= '0;
          end else begin
            r_gap <= r_gap + c_GW'(1);
          end
        end
        default: begin
          r_gap <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != c_ST_IDLE) || (w_count_nxt != '0);
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign ps2_clk  = r_clk;
  assign ps2_dat  = r_frame[0];
  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule

`default_nettype wire
